// File: rtl/cdc_tx_arbiter_pkg.sv
// cdc_tx_arbiter_pkg: FSM state encoding and default payload width for cdc_tx_arbiter.
package cdc_tx_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT_ACK = 2'd2} state_t;
  localparam int CDC_TX_WIDTH = 5;
endpackage

// File: rtl/cdc_tx_arbiter_sync.sv
// cdc_tx_arbiter_sync: 2-flop synchronizer with active-low asynchronous reset.
module cdc_tx_arbiter_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/cdc_tx_arbiter.sv
// cdc_tx_arbiter: 2-requester round-robin arbiter feeding a toggle-handshake CDC sender.
// Define CDC_TX_ACK_SYNC_EN to pass the returning ack toggle through a 2-flop synchronizer.
module cdc_tx_arbiter
  import cdc_tx_arbiter_pkg::*;
#(
  parameter int WIDTH = CDC_TX_WIDTH
) (
  input  logic             cdc_clk,
  input  logic             cdc_rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic [WIDTH-1:0] cdc_data,
  output logic             cdc_req_tgl,
  input  logic             cdc_ack_tgl,
  output logic             busy,
  output logic             grant_id
);
  state_t state, state_nxt;
  logic last, ack_s, gnt, take, ack_match;
`ifdef CDC_TX_ACK_SYNC_EN
  cdc_tx_arbiter_sync #(.WIDTH(1)) u_ack_sync (
    .clk   (cdc_clk),
    .rst_n (~cdc_rst),
    .d     (cdc_ack_tgl),
    .q     (ack_s)
  );
`else
  assign ack_s = cdc_ack_tgl;
`endif
  // ready is gated by reset too so it drops without waiting for an edge
  always_comb begin
    gnt        = (req0_valid && req1_valid) ? ~last : ~req0_valid;
    take       = (state == IDLE) && !cdc_rst && (req0_valid || req1_valid);
    ack_match  = (state == WAIT_ACK) && (ack_s == cdc_req_tgl);
    req0_ready = take && !gnt;
    req1_ready = take && gnt;
    busy       = state != IDLE;
    state_nxt  = (state == IDLE)     ? (take ? SEND : IDLE) :
                 (state == SEND)     ? WAIT_ACK :
                 (state == WAIT_ACK) ? (ack_match ? IDLE : WAIT_ACK) : IDLE;
  end
  always_ff @(posedge cdc_clk or posedge cdc_rst)
    if (cdc_rst) begin
      state       <= IDLE;
      cdc_req_tgl <= 1'b0;
      cdc_data    <= '0;
      grant_id    <= 1'b0;
      last        <= 1'b1;
    end else begin
      state <= state_nxt;
      if (take) begin
        cdc_data <= gnt ? req1_data : req0_data;
        grant_id <= gnt;
      end
      if (state == SEND) cdc_req_tgl <= ~cdc_req_tgl;
      if (ack_match) last <= grant_id;
    end
endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// tb_cdc_tx_arbiter: randomized and directed checks of cdc_tx_arbiter against a transfer-level model.
module tb_cdc_tx_arbiter;
  localparam int W = 5;
`ifdef CDC_TX_ACK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic cdc_clk = 0, cdc_rst = 1;
  logic req0_valid = 0, req1_valid = 0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, cdc_req_tgl, busy, grant_id;
  logic cdc_ack_tgl = 0;
  logic [W-1:0] cdc_data;
  int checks = 0, errors = 0;
  bit ack_loop = 1;
  int ack_dly = 0;
  bit rec = 0;
  int grants[$];
  bit m_active, m_sent, m_tgl, m_gid, m_last, m_s1, m_s2;
  logic [W-1:0] m_data;

  cdc_tx_arbiter #(.WIDTH(W)) dut (
    .cdc_clk(cdc_clk), .cdc_rst(cdc_rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .cdc_data(cdc_data), .cdc_req_tgl(cdc_req_tgl),
    .cdc_ack_tgl(cdc_ack_tgl), .busy(busy), .grant_id(grant_id)
  );

  always #5 cdc_clk = ~cdc_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    {m_active, m_sent, m_tgl, m_gid, m_s1, m_s2} = '0;
    m_last = 1;
    m_data = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ready0"}, req0_ready, 0);
    chk({tag, "_ready1"}, req1_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_data"}, cdc_data, 0);
    chk({tag, "_tgl"}, cdc_req_tgl, 0);
    chk({tag, "_gid"}, grant_id, 0);
  endtask

  // One clock cycle: destination ack behaviour, compare against model, advance model across the edge
  task automatic cyc();
    bit g, any, ack_s;
    if (ack_loop && cdc_req_tgl !== cdc_ack_tgl) begin
      if (ack_dly == 0) begin
        cdc_ack_tgl = cdc_req_tgl;
        ack_dly = $urandom_range(0, 3);
      end else ack_dly--;
    end
    #1;
    any = req0_valid || req1_valid;
    g = (req0_valid && req1_valid) ? !m_last : !req0_valid;
    chk("ready0", req0_ready, !m_active && any && !g);
    chk("ready1", req1_ready, !m_active && any && g);
    chk("busy", busy, m_active);
    chk("cdc_data", cdc_data, m_data);
    chk("req_tgl", cdc_req_tgl, m_tgl);
    chk("grant_id", grant_id, m_gid);
    if (rec && req0_ready) grants.push_back(0);
    if (rec && req1_ready) grants.push_back(1);
    ack_s = (LAT == 2) ? m_s2 : cdc_ack_tgl;
    if (!m_active && any) begin
      m_active = 1;
      m_sent = 0;
      m_gid = g;
      m_data = g ? req1_data : req0_data;
    end else if (m_active && !m_sent) begin
      m_sent = 1;
      m_tgl = !m_tgl;
    end else if (m_active && ack_s == m_tgl) begin
      m_active = 0;
      m_last = m_gid;
    end
    m_s2 = m_s1;
    m_s1 = cdc_ack_tgl;
    @(posedge cdc_clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      cyc();
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int n;
    model_reset();
    req0_valid = 1;
    req0_data = 5'h15;
    #3;
    check_outputs_zero("rst");
    @(posedge cdc_clk);
    #1;
    cdc_rst = 0;
    cyc();
    chk("first_data", cdc_data, 5'h15);
    chk("first_tgl", cdc_req_tgl, 0);
    req0_valid = 0;
    cyc();
    chk("first_tgl_flip", cdc_req_tgl, 1);
    chk("first_busy", busy, 1);
    wait_idle(20);

    // Ack withheld, then released: measure ack-to-IDLE latency
    ack_loop = 0;
    req1_valid = 1;
    req1_data = 5'h07;
    cyc();
    req1_valid = 0;
    cyc();
    for (int i = 0; i < 20; i++) begin
      req0_valid = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 1);
      cyc();
    end
    chk("hold_busy", busy, 1);
    chk("hold_data", cdc_data, 5'h07);
    req0_valid = 0;
    req1_valid = 0;
    cdc_ack_tgl = ~cdc_ack_tgl;
    n = 0;
    while (busy && n < 10) begin
      cyc();
      n++;
    end
    chk("ack_latency", n - 1, LAT);

    // Spurious ack toggle while idle
    for (int i = 0; i < 3; i++) cyc();
    cdc_ack_tgl = ~cdc_ack_tgl;
    for (int i = 0; i < 4; i++) cyc();
    chk("spur_busy", busy, 0);
    ack_loop = 1;
    req0_valid = 1;
    req0_data = 5'h1C;
    cyc();
    req0_valid = 0;
    wait_idle(20);
    chk("spur_done", busy, 0);

    // Reset during WAIT_ACK
    ack_loop = 0;
    req0_valid = 1;
    req0_data = 5'h1F;
    cyc();
    req0_valid = 1;
    cyc();
    cyc();
    chk("pre_rst_busy", busy, 1);
    #2;
    cdc_rst = 1;
    cdc_ack_tgl = 0;
    #1;
    check_outputs_zero("async_rst");
    model_reset();
    ack_dly = 0;
    @(posedge cdc_clk);
    #1;
    cdc_rst = 0;
    ack_loop = 1;
    req0_valid = 0;
    cyc();

    // Both valid with looped-back ack: grants alternate starting at 0
    req0_valid = 1;
    req1_valid = 1;
    req0_data = 5'h0A;
    req1_data = 5'h0B;
    rec = 1;
    n = 0;
    while (grants.size() < 4 && n < 100) begin
      cyc();
      n++;
    end
    rec = 0;
    chk("alt_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk($sformatf("alt_grant%0d", i), grants[i], i % 2);
    req0_valid = 0;
    req1_valid = 0;
    wait_idle(20);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_data = W'($urandom);
      req1_data = W'($urandom);
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
